// File: rtl/switch_irq_pio_if.sv
// Avalon-MM register bus between the HPS (initiator) and the switch port.
// The responder returns read data one cycle after the read strobe.
interface switch_irq_pio_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address,
      output avs_read,
      output avs_write,
      output avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address,
      input  avs_read,
      input  avs_write,
      input  avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/switch_irq_pio.sv
// Switch input port: synchronises and debounces the raw switch pins,
// captures configured edges per bit into a W1C register and drives a
// masked level interrupt. Register map (word addresses):
//   0 DATA (RO, debounced level)  1 MASK (RW)
//   2 EDGE (W1C, captured edges)  3 CFG  (RW, bit0 rising, bit1 falling)
module switch_irq_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [WIDTH-1:0]    switches_export,
   switch_irq_pio_if.slave     avs,
   output logic                irq
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;
   logic [WIDTH-1:0] stable_r;
   logic [WIDTH-1:0] stable_d_r;
   logic [CNT_W-1:0] cnt_r [WIDTH];
   logic [WIDTH-1:0] edge_capture_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [1:0]       edge_cfg_r;

   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] ev_s;
   logic [WIDTH-1:0] clr_s;
   logic [31:0]      rd_s;

   // Only the low WIDTH (or 2) bits of writedata carry meaning; the rest
   // are deliberately dropped.
   logic             unused_wdata_s;
   assign unused_wdata_s = ^avs.avs_writedata;

   // Two-flop synchroniser for the asynchronous switch pins.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= switches_export;
         sync_r <= meta_r;
      end
   end

   // Per-bit debounce: accept a new level only after it has differed from
   // the accepted level for DEBOUNCE_CYCLES consecutive samples.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         stable_r <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_r[i] == stable_r[i]) begin
               cnt_r[i] <= CNT_ZERO;
            end else if (cnt_r[i] == CNT_MAX) begin
               stable_r[i] <= sync_r[i];
               cnt_r[i]    <= CNT_ZERO;
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   // One-cycle delayed copy of the debounced level for edge detection.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         stable_d_r <= {WIDTH{1'b0}};
      end else begin
         stable_d_r <= stable_r;
      end
   end

   // Edge events filtered by the configured edge polarity.
   always_comb begin
      rise_s = stable_r & ~stable_d_r;
      fall_s = ~stable_r & stable_d_r;
      ev_s   = (rise_s & {WIDTH{edge_cfg_r[0]}}) | (fall_s & {WIDTH{edge_cfg_r[1]}});
   end

   // W1C clear mask from a write to the EDGE register.
   always_comb begin
      clr_s = {WIDTH{1'b0}};
      if (avs.avs_write && (avs.avs_address == 2'd2)) begin
         clr_s = avs.avs_writedata[WIDTH-1:0];
      end else begin
         clr_s = {WIDTH{1'b0}};
      end
   end

   // Edge capture: a new event wins over a same-cycle clear so none is lost.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         edge_capture_r <= {WIDTH{1'b0}};
      end else begin
         edge_capture_r <= (edge_capture_r & ~clr_s) | ev_s;
      end
   end

   // Writable control registers: interrupt mask and edge polarity.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         irq_mask_r <= {WIDTH{1'b0}};
         edge_cfg_r <= 2'b01;
      end else if (avs.avs_write) begin
         case (avs.avs_address)
            2'd1:    irq_mask_r <= avs.avs_writedata[WIDTH-1:0];
            2'd3:    edge_cfg_r <= avs.avs_writedata[1:0];
            default: irq_mask_r <= irq_mask_r;
         endcase
      end
   end

   // Read multiplexer over the pre-write register state.
   always_comb begin
      rd_s = 32'h0000_0000;
      case (avs.avs_address)
         2'd0:    rd_s = 32'(stable_r);
         2'd1:    rd_s = 32'(irq_mask_r);
         2'd2:    rd_s = 32'(edge_capture_r);
         2'd3:    rd_s = {30'h0000_0000, edge_cfg_r};
         default: rd_s = 32'h0000_0000;
      endcase
   end

   // Registered read data, held until the next read.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         avs.avs_readdata <= 32'h0000_0000;
      end else if (avs.avs_read) begin
         avs.avs_readdata <= rd_s;
      end
   end

   // Registered level interrupt from masked captured edges.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |(edge_capture_r & irq_mask_r);
      end
   end

endmodule

// File: tb/tb_switch_irq_pio.sv
// Directed bench for switch_irq_pio with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_switch_irq_pio;
   localparam int WIDTH = 4;
   localparam int DEB   = 4;

   typedef enum logic [2:0] {OP_IDLE, OP_SW, OP_WR, OP_RD, OP_RW, OP_HOLD} op_t;
   typedef struct {
      op_t         op;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          n;
      bit          chk_irq;
      logic        exp_irq;
   } vec_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] sw    = 4'h0;
   logic             irq;
   int               checks = 0;
   int               errors = 0;
   vec_t             tbl_a[$];
   vec_t             tbl_b[$];

   switch_irq_pio_if bus();

   switch_irq_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk_clk         (clk),
      .reset_reset_n   (rst_n),
      .switches_export (sw),
      .avs             (bus),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_rd(input logic [1:0] a);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      tick();
      bus.avs_read    = 1'b0;
   endtask

   task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      tick();
      bus.avs_write     = 1'b0;
   endtask

   task automatic do_rw(input logic [1:0] a, input logic [31:0] d);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_read      = 1'b1;
      bus.avs_write     = 1'b1;
      tick();
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
   endtask

   function automatic vec_t mk(op_t op, logic [1:0] a, logic [31:0] wd, logic [31:0] ex,
                               int n, bit ci, logic ei);
      vec_t v;
      v.op = op; v.addr = a; v.wdata = wd; v.exp = ex; v.n = n; v.chk_irq = ci; v.exp_irq = ei;
      return v;
   endfunction

   function automatic vec_t rd(logic [1:0] a, logic [31:0] ex, bit ci, logic ei);
      return mk(OP_RD, a, 32'h0, ex, 0, ci, ei);
   endfunction

   function automatic vec_t wr(logic [1:0] a, logic [31:0] d, bit ci, logic ei);
      return mk(OP_WR, a, d, 32'h0, 0, ci, ei);
   endfunction

   function automatic vec_t idle(int n, bit ci, logic ei);
      return mk(OP_IDLE, 2'd0, 32'h0, 32'h0, n, ci, ei);
   endfunction

   function automatic vec_t swv(logic [31:0] d);
      return mk(OP_SW, 2'd0, d, 32'h0, 0, 1'b0, 1'b0);
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      case (v.op)
         OP_IDLE: repeat (v.n) tick();
         OP_SW:   sw = v.wdata[WIDTH-1:0];
         OP_WR:   do_wr(v.addr, v.wdata);
         OP_RD:   do_rd(v.addr);
         OP_RW:   do_rw(v.addr, v.wdata);
         default: tick();
      endcase
      if (v.op == OP_RD || v.op == OP_RW || v.op == OP_HOLD)
         check({tag, " readdata"}, bus.avs_readdata, v.exp);
      if (v.chk_irq)
         check({tag, " irq"}, {31'h0, irq}, {31'h0, v.exp_irq});
   endtask

   initial begin
      bus.avs_address   = 2'd0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = 32'h0;

      // Reset state and mask setup.
      tbl_a.push_back(rd(2'd0, 32'h0, 1'b1, 1'b0));
      tbl_a.push_back(rd(2'd1, 32'h0, 1'b0, 1'b0));
      tbl_a.push_back(rd(2'd2, 32'h0, 1'b0, 1'b0));
      tbl_a.push_back(rd(2'd3, 32'h1, 1'b1, 1'b0));
      tbl_a.push_back(wr(2'd1, 32'hF, 1'b0, 1'b0));

      // Glitch, W1C, register access, falling-edge and disable behaviour.
      tbl_b.push_back(idle(2, 1'b1, 1'b1));
      tbl_b.push_back(mk(OP_HOLD, 2'd0, 32'h0, 32'h1, 0, 1'b0, 1'b0));
      tbl_b.push_back(swv(32'h5));
      tbl_b.push_back(idle(3, 1'b0, 1'b0));
      tbl_b.push_back(swv(32'h1));
      tbl_b.push_back(idle(10, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd0, 32'h1, 1'b1, 1'b1));
      tbl_b.push_back(rd(2'd2, 32'h1, 1'b1, 1'b1));
      tbl_b.push_back(wr(2'd0, 32'hF, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd0, 32'h1, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd2, 32'h2, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h1, 1'b1, 1'b1));
      tbl_b.push_back(wr(2'd2, 32'h1, 1'b0, 1'b0));
      tbl_b.push_back(idle(1, 1'b1, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h0, 1'b1, 1'b0));
      tbl_b.push_back(mk(OP_RW, 2'd1, 32'h3, 32'hF, 0, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd1, 32'h3, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd1, 32'hF, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd3, 32'h2, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd3, 32'h2, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd1, 32'h0, 1'b0, 1'b0));
      tbl_b.push_back(swv(32'h3));
      tbl_b.push_back(idle(12, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h0, 1'b1, 1'b0));
      tbl_b.push_back(swv(32'h1));
      tbl_b.push_back(idle(12, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h2, 1'b1, 1'b0));
      tbl_b.push_back(rd(2'd0, 32'h1, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd1, 32'hF, 1'b1, 1'b0));
      tbl_b.push_back(idle(1, 1'b1, 1'b1));
      tbl_b.push_back(wr(2'd3, 32'h0, 1'b0, 1'b0));
      tbl_b.push_back(swv(32'h0));
      tbl_b.push_back(idle(12, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd0, 32'h0, 1'b0, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h2, 1'b1, 1'b1));
      tbl_b.push_back(wr(2'd2, 32'hF, 1'b0, 1'b0));
      tbl_b.push_back(idle(1, 1'b1, 1'b0));
      tbl_b.push_back(rd(2'd2, 32'h0, 1'b0, 1'b0));
      tbl_b.push_back(wr(2'd3, 32'h1, 1'b0, 1'b0));

      // Reset with pins low.
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      foreach (tbl_a[i]) run_vec(tbl_a[i], $sformatf("A%0d", i));

      // Exact debounce latency: pin seen at edge 1, level accepted at edge 6,
      // captured at edge 7, interrupt at edge 8.
      sw = 4'h1;
      repeat (5) tick();
      do_rd(2'd0);
      check("lat data@6", bus.avs_readdata, 32'h0);
      do_rd(2'd0);
      check("lat data@7", bus.avs_readdata, 32'h1);
      check("lat irq@7", {31'h0, irq}, 32'h0);
      do_rd(2'd2);
      check("lat edge@8", bus.avs_readdata, 32'h1);
      check("lat irq@8", {31'h0, irq}, 32'h1);

      foreach (tbl_b[i]) run_vec(tbl_b[i], $sformatf("B%0d", i));

      // W1C write on the same edge the bit0 rising event is captured.
      sw = 4'h1;
      repeat (6) tick();
      do_wr(2'd2, 32'h1);
      do_rd(2'd2);
      check("collide edge", bus.avs_readdata, 32'h1);
      check("collide irq", {31'h0, irq}, 32'h1);

      // Reset in the middle of a debounce count.
      sw    = 4'h0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      sw = 4'h1;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst irq", {31'h0, irq}, 32'h0);
      check("midrst rdata", bus.avs_readdata, 32'h0);
      repeat (5) tick();
      do_rd(2'd0);
      check("midrst data@6", bus.avs_readdata, 32'h0);
      do_rd(2'd0);
      check("midrst data@7", bus.avs_readdata, 32'h1);
      do_rd(2'd3);
      check("midrst cfg", bus.avs_readdata, 32'h1);
      do_rd(2'd1);
      check("midrst mask", bus.avs_readdata, 32'h0);
      check("midrst irq end", {31'h0, irq}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
